demo_scene_sequencer: RTL and testbench

Frame-rate scene controller for the VGA demo. Steps through a fixed loop of four scenes, each built from the starfield, 3D checker plane and scroller layers. Each scene is faded in, held for a fixed time, then faded out. Its outputs gate and scale the pixel colour path ahead of the Bayer dither. All state changes occur only on the frame tick, in vertical blanking, so no layer is switched mid-frame.

---
 rtl/demo_scene_sequencer_if.sv | 26 ++
 rtl/demo_scene_sequencer.sv | 138 +++++++++++++
 tb/tb_demo_scene_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/demo_scene_sequencer_if.sv
// Control/status bundle between the frame timing logic and the scene sequencer.
// master drives tick/pause/skip; slave returns the scene, the layer enables and the brightness.
interface demo_scene_sequencer_if;
    logic        frame_tick;
    logic        pause_n;
    logic        skip;
    logic [1:0]  scene;
    logic        en_starfield;
    logic        en_plane;
    logic        en_scroller;
    logic [5:0]  brightness;
    logic        scene_change;
    logic [11:0] frame_in_scene;

    modport master (
        output frame_tick, pause_n, skip,
        input  scene, en_starfield, en_plane, en_scroller,
               brightness, scene_change, frame_in_scene
    );

    modport slave (
        input  frame_tick, pause_n, skip,
        output scene, en_starfield, en_plane, en_scroller,
               brightness, scene_change, frame_in_scene
    );
endinterface

// File: rtl/demo_scene_sequencer.sv
// Frame-rate scene loop: fades each scene in, holds it, fades it out. All outputs are registered.
// Outputs move only on unpaused frame ticks, one edge after the tick; there is no backpressure.
module demo_scene_sequencer #(
    parameter int SCENE0_FRAMES = 256,
    parameter int SCENE1_FRAMES = 512,
    parameter int SCENE2_FRAMES = 768,
    parameter int SCENE3_FRAMES = 512,
    parameter int FADE_STEP     = 2
) (
    input  logic                   clk48,
    input  logic                   rst_n,
    demo_scene_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {FADE_IN, HOLD, FADE_OUT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  scene_q, scene_d;
    logic [5:0]  bright_q, bright_d;
    logic [11:0] hold_q, hold_d;
    logic [11:0] fis_q, fis_d;
    logic        change_q, change_d;
    logic        skip_pend_q, skip_pend_d;
    logic [2:0]  en_q, en_d;

    logic        tick;
    logic        skip_now;
    logic [11:0] hold_last;
    logic [6:0]  up_sum;
    logic signed [6:0] down_diff;

    assign tick      = bus.frame_tick & bus.pause_n;
    assign skip_now  = skip_pend_q | bus.skip;
    assign up_sum    = {1'b0, bright_q} + 7'(FADE_STEP);
    assign down_diff = $signed({1'b0, bright_q}) - $signed(7'(FADE_STEP));

    always_comb begin
        hold_last = 12'(SCENE0_FRAMES - 1);
        case (scene_q)
            2'd1:    hold_last = 12'(SCENE1_FRAMES - 1);
            2'd2:    hold_last = 12'(SCENE2_FRAMES - 1);
            2'd3:    hold_last = 12'(SCENE3_FRAMES - 1);
            default: hold_last = 12'(SCENE0_FRAMES - 1);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        scene_d     = scene_q;
        bright_d    = bright_q;
        hold_d      = hold_q;
        fis_d       = fis_q;
        change_d    = 1'b0;
        skip_pend_d = skip_pend_q;

        // A skip seen while already fading out has nothing left to shorten.
        if (bus.skip && state_q != FADE_OUT)
            skip_pend_d = 1'b1;

        if (tick) begin
            if (fis_q != 12'hFFF)
                fis_d = fis_q + 12'd1;
            if (state_q != FADE_OUT)
                skip_pend_d = 1'b0;

            case (state_q)
                FADE_IN: begin
                    if (skip_now) begin
                        state_d = FADE_OUT;
                    end else if (up_sum >= 7'd63) begin
                        bright_d = 6'd63;
                        state_d  = HOLD;
                        hold_d   = 12'd0;
                    end else begin
                        bright_d = up_sum[5:0];
                    end
                end
                HOLD: begin
                    if (skip_now || hold_q == hold_last)
                        state_d = FADE_OUT;
                    else
                        hold_d = hold_q + 12'd1;
                end
                FADE_OUT: begin
                    if (down_diff <= 7'sd0) begin
                        bright_d = 6'd0;
                        scene_d  = scene_q + 2'd1;
                        state_d  = FADE_IN;
                        fis_d    = 12'd0;
                        change_d = 1'b1;
                    end else begin
                        bright_d = down_diff[5:0];
                    end
                end
                default: state_d = FADE_IN;
            endcase
        end
    end

    // Enables are decoded from the next scene so they switch on the same edge as scene.
    always_comb begin
        case (scene_d)
            2'd0:    en_d = 3'b100;
            2'd1:    en_d = 3'b101;
            2'd2:    en_d = 3'b111;
            default: en_d = 3'b011;
        endcase
    end

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            state_q     <= FADE_IN;
            scene_q     <= 2'd0;
            bright_q    <= 6'd0;
            hold_q      <= 12'd0;
            fis_q       <= 12'd0;
            change_q    <= 1'b0;
            skip_pend_q <= 1'b0;
            en_q        <= 3'b100;
        end else begin
            state_q     <= state_d;
            scene_q     <= scene_d;
            bright_q    <= bright_d;
            hold_q      <= hold_d;
            fis_q       <= fis_d;
            change_q    <= change_d;
            skip_pend_q <= skip_pend_d;
            en_q        <= en_d;
        end
    end

    assign bus.scene          = scene_q;
    assign bus.en_starfield   = en_q[2];
    assign bus.en_plane       = en_q[1];
    assign bus.en_scroller    = en_q[0];
    assign bus.brightness     = bright_q;
    assign bus.scene_change   = change_q;
    assign bus.frame_in_scene = fis_q;
endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Directed bench for demo_scene_sequencer: scene 0 holds 4 frames, scenes 1-3 hold 2, fade step 2.
module tb_demo_scene_sequencer;
    logic clk48 = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;

    demo_scene_sequencer_if bus ();

    demo_scene_sequencer #(
        .SCENE0_FRAMES(4),
        .SCENE1_FRAMES(2),
        .SCENE2_FRAMES(2),
        .SCENE3_FRAMES(2),
        .FADE_STEP(2)
    ) dut (
        .clk48 (clk48),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk48 = ~clk48;

    always @(negedge clk48)
        if (bus.scene_change === 1'b1)
            pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk48);
            bus.frame_tick = 1'b1;
            @(negedge clk48);
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_skip();
        @(negedge clk48);
        bus.skip = 1'b1;
        @(negedge clk48);
        bus.skip = 1'b0;
    endtask

    function automatic logic [31:0] enables();
        return {29'd0, bus.en_starfield, bus.en_plane, bus.en_scroller};
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_scene"}, 32'(bus.scene), 0);
        chk({tag, "_bright"}, 32'(bus.brightness), 0);
        chk({tag, "_en"}, enables(), 3'b100);
        chk({tag, "_chg"}, 32'(bus.scene_change), 0);
        chk({tag, "_fis"}, 32'(bus.frame_in_scene), 0);
    endtask

    logic [2:0] exp_en [4];

    initial begin
        exp_en[0] = 3'b100;
        exp_en[1] = 3'b101;
        exp_en[2] = 3'b111;
        exp_en[3] = 3'b011;

        // Ticks during reset must be ignored.
        bus.frame_tick = 1'b1;
        bus.pause_n    = 1'b1;
        bus.skip       = 1'b0;
        repeat (3) @(negedge clk48);
        bus.frame_tick = 1'b0;
        rst_n = 1'b1;
        @(negedge clk48);
        chk_reset_state("rst");

        // Scene 0: 32-tick fade in, 4-tick hold, 32-tick fade out.
        ticks(1);
        chk("first_tick_bright", 32'(bus.brightness), 2);
        ticks(30);
        chk("fade_in_31", 32'(bus.brightness), 62);
        ticks(1);
        chk("fade_in_done", 32'(bus.brightness), 63);
        chk("fis_32", 32'(bus.frame_in_scene), 32);
        ticks(4);
        chk("hold_end_bright", 32'(bus.brightness), 63);
        chk("hold_end_scene", 32'(bus.scene), 0);
        ticks(1);
        chk("fade_out_1", 32'(bus.brightness), 61);
        ticks(30);
        chk("fade_out_31", 32'(bus.brightness), 1);
        chk("fade_out_31_scene", 32'(bus.scene), 0);
        chk("no_pulse_yet", 32'(pulses), 0);
        ticks(1);
        chk("s1_bright", 32'(bus.brightness), 0);
        chk("s1_scene", 32'(bus.scene), 1);
        chk("s1_en", enables(), 3'b101);
        chk("s1_chg", 32'(bus.scene_change), 1);
        chk("s1_fis", 32'(bus.frame_in_scene), 0);
        @(negedge clk48);
        chk("s1_chg_clear", 32'(bus.scene_change), 0);

        // Scene 1: pause mid fade-in, skip during the pause.
        ticks(10);
        chk("s1_b20", 32'(bus.brightness), 20);
        chk("s1_fis10", 32'(bus.frame_in_scene), 10);
        bus.pause_n = 1'b0;
        ticks(5);
        pulse_skip();
        ticks(5);
        chk("pause_bright", 32'(bus.brightness), 20);
        chk("pause_fis", 32'(bus.frame_in_scene), 10);
        chk("pause_scene", 32'(bus.scene), 1);
        bus.pause_n = 1'b1;
        ticks(1);
        chk("skip_after_pause_b", 32'(bus.brightness), 20);
        chk("skip_after_pause_fis", 32'(bus.frame_in_scene), 11);
        ticks(1);
        chk("skip_fade_out", 32'(bus.brightness), 18);
        ticks(9);
        chk("s2_scene", 32'(bus.scene), 2);
        chk("s2_en", enables(), 3'b111);
        chk("s2_bright", 32'(bus.brightness), 0);

        // Scene 2: skip while holding, then reset mid fade-out.
        ticks(33);
        chk("s2_hold_b", 32'(bus.brightness), 63);
        pulse_skip();
        ticks(1);
        chk("hold_skip_b", 32'(bus.brightness), 63);
        ticks(1);
        chk("hold_skip_61", 32'(bus.brightness), 61);
        ticks(15);
        chk("s2_b31", 32'(bus.brightness), 31);
        chk("s2_b31_scene", 32'(bus.scene), 2);
        @(negedge clk48);
        rst_n = 1'b0;
        bus.frame_tick = 1'b1;
        @(negedge clk48);
        rst_n = 1'b1;
        bus.frame_tick = 1'b0;
        chk_reset_state("midrst");
        ticks(1);
        chk("midrst_fade_in", 32'(bus.brightness), 2);

        // Full loop from a clean reset; a skip during scene 0 fade-out must be dropped.
        @(negedge clk48);
        rst_n = 1'b0;
        @(negedge clk48);
        rst_n = 1'b1;
        pulses = 0;
        ticks(41);
        chk("loop_s0_b53", 32'(bus.brightness), 53);
        pulse_skip();
        ticks(27);
        chk("loop_scene1", 32'(bus.scene), 1);
        chk("loop_en1", enables(), 32'(exp_en[1]));
        for (int s = 2; s <= 4; s++) begin
            ticks(66);
            chk($sformatf("loop_scene%0d", s % 4), 32'(bus.scene), 32'(s % 4));
            chk($sformatf("loop_en%0d", s % 4), enables(), 32'(exp_en[s % 4]));
        end
        @(negedge clk48);
        chk("loop_pulses", 32'(pulses), 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
